// File: rtl/pop_mem_arbiter_pkg.sv
// Shared definitions for the population-RAM arbiter.
// Holds the controller phase codes, requester indices, common widths and the
// phase-to-permitted-requester mask table.
package pop_mem_arbiter_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned PHASE_W = 3;
    localparam int unsigned STALL_W = 16;

    // Top-level controller phases
    typedef enum logic [PHASE_W-1:0] {
        PH_INIT     = 3'b000,
        PH_EVAL     = 3'b001,
        PH_SORT     = 3'b010,
        PH_SORT_MUT = 3'b011,
        PH_REEVAL   = 3'b101,
        PH_DONE     = 3'b110
    } phase_e;

    // Requester slot indices on the arbiter bus
    typedef enum logic [PTR_W-1:0] {
        REQ_INIT = 2'd0,
        REQ_EVAL = 2'd1,
        REQ_SORT = 2'd2,
        REQ_MUT  = 2'd3
    } req_id_e;

    // Requesters allowed to touch the RAM in each phase; unknown codes allow none
    function automatic logic [NUM_REQ-1:0] phase_mask(input logic [PHASE_W-1:0] phase);
        logic [NUM_REQ-1:0] m;
        m = '0;
        case (phase)
            PH_INIT:     m[REQ_INIT] = 1'b1;
            PH_EVAL:     m[REQ_EVAL] = 1'b1;
            PH_SORT:     m[REQ_SORT] = 1'b1;
            PH_SORT_MUT: begin
                m[REQ_SORT] = 1'b1;
                m[REQ_MUT]  = 1'b1;
            end
            PH_REEVAL:   m[REQ_EVAL] = 1'b1;
            default:     m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pop_mem_arbiter_if.sv
// Requester-side bus of the population-RAM arbiter.
// req/we/addr/wdata : per-requester access request, packed, slot i in slice i
// ack               : one-hot completion pulse, one cycle after the grant
// rdata             : read data, valid while the matching ack is high
interface pop_mem_arbiter_if
    import pop_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) ();

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;

    // Requester side
    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    // Arbiter side
    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/pop_mem_arbiter_rr_pick4.sv
// Combinational 4-way round-robin selector.
// eligible : requesters that may be granted this cycle
// ptr      : last granted index; search begins at ptr+1 and wraps
// onehot   : selected requester, zero when nothing is eligible
// valid    : a requester was selected
module rr_pick4
    import pop_mem_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic               valid
);

    // First eligible slot walking upward from ptr+1, modulo 4
    always_comb begin
        logic [PTR_W-1:0] idx;
        onehot = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = ptr + PTR_W'(k);
            if (!valid && eligible[idx]) begin
                onehot[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pop_mem_arbiter.sv
// Single-port population-RAM arbiter for the GA controller.
// CLOCK_50          : system clock, rising edge
// reset             : synchronous, active-high
// state_controller  : controller phase, selects the permitted requesters
// bus               : requester bus (req/we/addr/wdata in, ack/rdata out)
// mem_en/mem_we     : RAM enable and write strobe, driven in the grant cycle
// mem_addr/mem_wdata: RAM address/data, holding last value while idle
// mem_rdata         : RAM read data, one cycle after mem_en
// stall_cnt         : saturating count of cycles a permitted request waited
module pop_mem_arbiter
    import pop_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [PHASE_W-1:0]  state_controller,
    pop_mem_arbiter_if.slave    bus,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [STALL_W-1:0]  stall_cnt
);

    localparam logic [PTR_W-1:0]   RR_RESET = PTR_W'(NUM_REQ - 1);
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    logic [NUM_REQ-1:0] mask_c;
    logic [NUM_REQ-1:0] eligible_c;
    logic [NUM_REQ-1:0] gnt_c;
    logic               gnt_v_c;
    logic [PTR_W-1:0]   gnt_idx_c;
    logic               waiting_c;
    logic [ADDR_W-1:0]  sel_addr_c;
    logic [DATA_W-1:0]  sel_wdata_c;

    // gnt_q doubles as the busy requester and the pending ack
    logic [NUM_REQ-1:0] gnt_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [STALL_W-1:0] stall_q;

    assign mask_c = phase_mask(state_controller);

    // Requester granted last cycle sits out one cycle so it can drop req after ack
    assign eligible_c = reset ? '0 : (bus.req & mask_c & ~gnt_q);

    rr_pick4 u_pick (
        .eligible (eligible_c),
        .ptr      (rr_ptr_q),
        .onehot   (gnt_c),
        .valid    (gnt_v_c)
    );

    // One-hot grant to index
    always_comb begin
        gnt_idx_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_c[i]) begin
                gnt_idx_c = PTR_W'(i);
            end
        end
    end

    assign sel_addr_c  = bus.addr[32'(gnt_idx_c) * ADDR_W +: ADDR_W];
    assign sel_wdata_c = bus.wdata[32'(gnt_idx_c) * DATA_W +: DATA_W];

    // RAM port: live from the winner, otherwise hold the last address/data
    always_comb begin
        mem_en    = gnt_v_c;
        mem_we    = gnt_v_c & bus.we[gnt_idx_c];
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (reset) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (gnt_v_c) begin
            mem_addr  = sel_addr_c;
            mem_wdata = sel_wdata_c;
        end
    end

    // Any permitted requester other than the winner is waiting this cycle
    assign waiting_c = |(bus.req & mask_c & ~gnt_c);

    // Reset forces outputs low immediately so a pending ack is cancelled
    assign bus.ack   = reset ? '0 : gnt_q;
    assign bus.rdata = reset ? '0 : ((|gnt_q) ? mem_rdata : rdata_q);
    assign stall_cnt = reset ? '0 : stall_q;

    // Arbiter state
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            gnt_q    <= '0;
            rr_ptr_q <= RR_RESET;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            stall_q  <= '0;
        end else begin
            gnt_q   <= gnt_c;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            rdata_q <= bus.rdata;
            if (gnt_v_c) begin
                rr_ptr_q <= gnt_idx_c;
            end
            if (waiting_c && (stall_q != STALL_MAX)) begin
                stall_q <= stall_q + STALL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pop_mem_arbiter.sv
// Self-checking bench for pop_mem_arbiter: directed scenarios followed by
// randomized traffic, checked against a behavioural model with a scoreboard.
module tb_pop_mem_arbiter;
    import pop_mem_arbiter_pkg::*;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;
    localparam int unsigned DEPTH = 64;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic [2:0]    state_controller;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   stall_cnt;

    always #5 CLOCK_50 = ~CLOCK_50;

    pop_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    pop_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLOCK_50         (CLOCK_50),
        .reset            (reset),
        .state_controller (state_controller),
        .bus              (bus),
        .mem_en           (mem_en),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .stall_cnt        (stall_cnt)
    );

    // Environment RAM with registered read
    logic [DW-1:0] ram [DEPTH];
    always @(posedge CLOCK_50) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Scoreboard
    typedef struct {
        int          idx;
        bit          is_wr;
        logic [DW-1:0] data;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    int            m_rr;
    int            m_busy;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    int unsigned   m_stall;
    logic [DW-1:0] ref_mem [DEPTH];

    // Requester stimulus state
    bit            r_req   [4];
    bit            r_we    [4];
    logic [AW-1:0] r_addr  [4];
    logic [DW-1:0] r_wdata [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Which requesters each phase lets through
    function automatic bit allowed(input logic [2:0] ph, input int i);
        case (ph)
            3'b000:         return i == 0;
            3'b001, 3'b101: return i == 1;
            3'b010:         return i == 2;
            3'b011:         return (i == 2) || (i == 3);
            default:        return 1'b0;
        endcase
    endfunction

    task automatic model(input bit rst, input logic [2:0] ph);
        int g = -1;
        bit wait_any = 1'b0;
        check("stall_cnt", 64'(stall_cnt), rst ? 64'd0 : 64'(m_stall));
        if (rst) begin
            check("rst_mem_en", 64'(mem_en), 64'd0);
            check("rst_mem_we", 64'(mem_we), 64'd0);
            check("rst_mem_addr", 64'(mem_addr), 64'd0);
            check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
            m_rr = 3; m_busy = -1; m_addr = '0; m_wdata = '0; m_stall = 0;
            exp_q.delete();
            return;
        end
        for (int k = 1; k <= 4; k++) begin
            int j = (m_rr + k) % 4;
            if (g < 0 && r_req[j] && allowed(ph, j) && j != m_busy) g = j;
        end
        for (int j = 0; j < 4; j++) begin
            if (r_req[j] && allowed(ph, j) && j != g) wait_any = 1'b1;
        end
        check("mem_en", 64'(mem_en), 64'(g >= 0));
        if (g >= 0) begin
            exp_t e;
            check("mem_we", 64'(mem_we), 64'(r_we[g]));
            check("mem_addr", 64'(mem_addr), 64'(r_addr[g]));
            check("mem_wdata", 64'(mem_wdata), 64'(r_wdata[g]));
            e.idx = g; e.is_wr = r_we[g]; e.data = ref_mem[r_addr[g]]; e.due = cyc + 1;
            exp_q.push_back(e);
            if (r_we[g]) ref_mem[r_addr[g]] = r_wdata[g];
            m_rr = g;
            m_addr = r_addr[g];
            m_wdata = r_wdata[g];
        end else begin
            check("idle_mem_we", 64'(mem_we), 64'd0);
            check("idle_mem_addr", 64'(mem_addr), 64'(m_addr));
            check("idle_mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        end
        m_busy = g;
        if (wait_any && m_stall < 32'hFFFF) m_stall++;
    endtask

    // Drive one cycle of inputs at the falling edge, then check against the model
    task automatic step(input bit rst, input logic [2:0] ph);
        @(negedge CLOCK_50);
        reset = rst;
        state_controller = ph;
        for (int i = 0; i < 4; i++) begin
            bus.req[i] = r_req[i];
            bus.we[i]  = r_we[i];
            bus.addr[i*AW +: AW]  = r_addr[i];
            bus.wdata[i*DW +: DW] = r_wdata[i];
        end
        cyc++;
        #1;
        model(rst, ph);
    endtask

    task automatic set_req(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        r_req[i] = 1'b1; r_we[i] = w; r_addr[i] = a; r_wdata[i] = d;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) r_req[i] = 1'b0;
    endtask

    // Monitor: compare acks against the scoreboard queue
    initial begin
        exp_t e;
        forever begin
            @(negedge CLOCK_50);
            #2;
            if (bus.ack !== 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check("spurious_ack", 64'(bus.ack), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack", 64'(bus.ack), 64'(1) << e.idx);
                    check("ack_cycle", 64'(cyc), 64'(e.due));
                    if (!e.is_wr) check("rdata", 64'(bus.rdata), 64'(e.data));
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                check("missing_ack", 64'(bus.ack), 64'(1) << e.idx);
            end
        end
    end

    initial begin
        logic [2:0] ph;
        reset = 1'b1;
        state_controller = 3'b000;
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
        for (int i = 0; i < 4; i++) begin
            r_req[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        ram[7] = 32'h1234_5678;
        ref_mem[7] = 32'h1234_5678;
        m_rr = 3; m_busy = -1; m_addr = '0; m_wdata = '0; m_stall = 0;

        step(1'b1, 3'b000);
        step(1'b1, 3'b000);

        // Single write from init requester
        set_req(0, 1'b1, AW'(5), 32'hA5A5_A5A5);
        step(1'b0, 3'b000);
        clear_all();
        step(1'b0, 3'b000);
        step(1'b0, 3'b000);

        // Sort and mutation alternate every cycle
        set_req(2, 1'b0, AW'(5), 32'h0);
        set_req(3, 1'b0, AW'(7), 32'h0);
        repeat (6) step(1'b0, 3'b011);
        clear_all();
        step(1'b0, 3'b011);

        // Evaluation phase with everyone requesting
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, AW'(10 + i), 32'h0);
        repeat (6) step(1'b0, 3'b001);
        clear_all();
        step(1'b0, 3'b001);

        // Read preloaded word
        set_req(1, 1'b0, AW'(7), 32'h0);
        step(1'b0, 3'b101);
        clear_all();
        step(1'b0, 3'b101);

        // Phase change right after a sort grant
        set_req(2, 1'b0, AW'(3), 32'h0);
        step(1'b0, 3'b010);
        r_req[2] = 1'b0;
        set_req(3, 1'b0, AW'(4), 32'h0);
        step(1'b0, 3'b011);
        clear_all();
        step(1'b0, 3'b011);

        // Reset in the ack cycle, then a no-grant phase
        set_req(0, 1'b1, AW'(9), 32'hDEAD_BEEF);
        step(1'b0, 3'b000);
        clear_all();
        step(1'b1, 3'b000);
        step(1'b0, 3'b000);
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, AW'(i), 32'h0);
        repeat (4) step(1'b0, 3'b110);
        clear_all();
        step(1'b0, 3'b000);

        // Randomized traffic
        ph = 3'b011;
        for (int n = 0; n < 3000; n++) begin
            bit rst;
            if ($urandom_range(11) == 0) ph = 3'($urandom_range(7));
            for (int i = 0; i < 4; i++) begin
                if (r_req[i]) begin
                    if (m_busy == i) begin
                        if ($urandom_range(3) != 0) r_req[i] = 1'b0;
                        else set_req(i, 1'($urandom_range(1)), AW'($urandom_range(DEPTH-1)), $urandom);
                    end else if ($urandom_range(15) == 0) begin
                        r_req[i] = 1'b0;
                    end
                end else if ($urandom_range(2) == 0) begin
                    set_req(i, 1'($urandom_range(1)), AW'($urandom_range(DEPTH-1)), $urandom);
                end
            end
            rst = ($urandom_range(199) == 0);
            step(rst, ph);
        end

        clear_all();
        repeat (3) step(1'b0, 3'b000);
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pop_mem_arbiter.md
POP_MEM_ARBITER -- requirements
Module: pop_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, population-RAM word address width.
REQ-002 Parameter DATA_W, default 32, chromosome word width.
REQ-003 CLOCK_50  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 state_controller  input  3  top-level controller phase; selects the permitted requesters.
REQ-006 req  input  4  per-requester access request, index 0 init, 1 evaluation, 2 sort, 3 mutation; held high until ack.
REQ-007 we  input  4  per-requester write enable, qualified by req.
REQ-008 addr  input  4*ADDR_W  per-requester address, packed, requester i in slice i.
REQ-009 wdata  input  4*DATA_W  per-requester write data, packed as addr.
REQ-010 ack  output  4  one-hot, one-cycle pulse marking completion of that requester's access.
REQ-011 rdata  output  DATA_W  read data, valid in the ack cycle of a read.
REQ-012 mem_en, mem_we  output  1 each  single-port RAM enable and write strobe.
REQ-013 mem_addr / mem_wdata  output  ADDR_W / DATA_W  RAM address and write data.
REQ-014 mem_rdata  input  DATA_W  RAM read data, registered, one-cycle latency after mem_en.
REQ-015 stall_cnt  output  16  saturating count of cycles in which a permitted request waited.

Function
REQ-016 Phase mask: 000 -> {0}; 001 -> {1}; 010 -> {2}; 011 -> {2,3}; 101 -> {1}; 110 and all other codes -> {} (no grants).
REQ-017 Eligible set each cycle: req AND phase mask AND NOT busy_id, where busy_id is the requester whose access issued in the previous cycle.
REQ-018 At most one grant per cycle, chosen round-robin: search starts at rr_ptr+1 mod 4, and rr_ptr SHALL load the granted index.
REQ-019 Grant cycle N: mem_en=1, mem_we=we[i], mem_addr=addr[i], mem_wdata=wdata[i], all driven combinationally from the selected requester.
REQ-020 Cycle N+1: ack[i]=1 for exactly one cycle, and rdata=mem_rdata; rdata is don't-care for writes.
REQ-021 Back-to-back grants to different requesters SHALL be allowed in consecutive cycles, giving a throughput of one access per cycle.
REQ-022 The same requester SHALL NOT be granted in N+1 even if its req is still high, so the requester can drop req after seeing ack.
REQ-023 When no requester is eligible: mem_en=0, mem_we=0, and mem_addr/mem_wdata hold their last values.
REQ-024 A phase change with an access outstanding SHALL still deliver its ack in N+1; the new mask applies to grants from the change cycle onward.
REQ-025 Simultaneous requests SHALL never grant more than one requester; ack is always one-hot or zero.
REQ-026 stall_cnt increments when (req AND mask) is nonzero and no grant issues, or when a masked-in requester other than the granted one is requesting; it SHALL saturate at 16'hFFFF.
REQ-027 A req that is deasserted before its grant SHALL be dropped silently, with no ack.

Reset
REQ-028 While reset=1: ack=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, rr_ptr=3, busy_id invalid, stall_cnt=0.
REQ-029 Reset asserted mid-access SHALL cancel the pending ack; no ack SHALL appear in the cycle after reset releases.

Structure
REQ-030 A shared package SHALL hold the controller phase codes (000, 001, 010, 011, 101, 110), the requester indices, and the phase-to-mask table.
REQ-031 A single sub-module rr_pick4 (combinational 4-way round-robin selector: inputs eligible and ptr, outputs onehot and valid) is natural; everything else SHALL live in pop_mem_arbiter.

Verification
REQ-032 Reset, state_controller=000, req=0001 write addr 5 data 0xA5A5A5A5 -> mem_en/mem_we=1, mem_addr=5 in cycle 1; ack=0001 in cycle 2.
REQ-033 Phase 011, req=1100 held continuously, reads -> grants alternate 2,3,2,3 every cycle; each ack lands one cycle after its grant; stall_cnt increments every cycle.
REQ-034 Phase 001, req=1111 -> only requester 1 is granted; thereafter one grant every 2 cycles (busy exclusion); requesters 0, 2, 3 never receive ack.
REQ-035 Preload RAM addr 7 = 0x12345678; phase 101, requester 1 reads addr 7 -> rdata=0x12345678 with ack=0010.
REQ-036 Phase switches 010->011 in the cycle requester 2 was granted -> ack[2] is still delivered next cycle; requester 3 is eligible in that same next cycle.
REQ-037 Reset asserted in the cycle after a grant -> ack=0 in that cycle and after; phase 110 with req=1111 -> mem_en stays 0.
